// File: rtl/pcr_pkg.sv
// Shared definitions for the PCR request master: default widths, default
// reply timeout, the FSM state encoding and the counter-width helper.
package pcr_pkg;

    localparam int PCR_ADDR_W  = 5;
    localparam int PCR_DATA_W  = 64;
    localparam int PCR_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } pcr_state_e;

    // Width that holds every value 0..timeout.
    function automatic int ctr_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pcr_timeout_ctr.sv
// Reply-wait counter. Counts cycles spent waiting for a PCR reply and flags
// the last permitted cycle. It saturates there, so it never wraps.
module pcr_timeout_ctr
    import pcr_pkg::*;
#(
    parameter int TIMEOUT = PCR_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = ctr_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    assign expired = (r_count == LAST);

    // Cycle counter: cleared on entry to WAIT, holds once it reaches LAST.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/pcr_req_master.sv
// PCR request master: takes one host command at a time, issues it to the PCR
// file, waits for the reply (or a timeout) and returns a response to the host.
module pcr_req_master
    import pcr_pkg::*;
#(
    parameter int ADDR_W  = PCR_ADDR_W,
    parameter int DATA_W  = PCR_DATA_W,
    parameter int TIMEOUT = PCR_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic              io_cmd_bits_rw,
    input  logic [ADDR_W-1:0] io_cmd_bits_addr,
    input  logic [DATA_W-1:0] io_cmd_bits_data,
    output logic              io_pcr_req_valid,
    input  logic              io_pcr_req_ready,
    output logic              io_pcr_req_bits_rw,
    output logic [ADDR_W-1:0] io_pcr_req_bits_addr,
    output logic [DATA_W-1:0] io_pcr_req_bits_data,
    input  logic              io_pcr_rep_valid,
    input  logic [DATA_W-1:0] io_pcr_rep_bits,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [DATA_W-1:0] io_resp_bits_data,
    output logic              io_resp_bits_err
);

    pcr_state_e        r_state;
    logic              r_cmd_ready;
    logic              r_req_valid;
    logic              r_resp_valid;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_ctr_clear;
    logic              w_ctr_enable;
    logic              w_ctr_expired;

    // The wait count restarts on the request handshake and advances only
    // while waiting without a reply.
    assign w_ctr_clear  = (r_state == ST_REQ) && io_pcr_req_ready;
    assign w_ctr_enable = (r_state == ST_WAIT) && !io_pcr_rep_valid;

    pcr_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_ctr_clear),
        .enable  (w_ctr_enable),
        .expired (w_ctr_expired)
    );

    // Transaction FSM with registered handshake outputs and captured payloads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_req_valid  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_cmd_valid) begin
                        r_rw        <= io_cmd_bits_rw;
                        r_addr      <= io_cmd_bits_addr;
                        r_wdata     <= io_cmd_bits_data;
                        r_cmd_ready <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (io_pcr_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A reply arriving on the timeout cycle still wins.
                    if (io_pcr_rep_valid) begin
                        r_rdata      <= io_pcr_rep_bits;
                        r_err        <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (w_ctr_expired) begin
                        r_rdata      <= '0;
                        r_err        <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (io_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cmd_ready  <= 1'b1;
                    r_req_valid  <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_cmd_ready         = r_cmd_ready;
    assign io_pcr_req_valid     = r_req_valid;
    assign io_pcr_req_bits_rw   = r_rw;
    assign io_pcr_req_bits_addr = r_addr;
    assign io_pcr_req_bits_data = r_wdata;
    assign io_resp_valid        = r_resp_valid;
    assign io_resp_bits_data    = r_rdata;
    assign io_resp_bits_err     = r_err;

endmodule

// File: tb/tb_pcr_req_master.sv
// Directed bench for pcr_req_master with TIMEOUT=4. Expected responses are
// queued when a command is accepted and compared when the response appears.
module tb_pcr_req_master;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              io_cmd_valid = 1'b0;
    logic              io_cmd_ready;
    logic              io_cmd_bits_rw = 1'b0;
    logic [ADDR_W-1:0] io_cmd_bits_addr = '0;
    logic [DATA_W-1:0] io_cmd_bits_data = '0;
    logic              io_pcr_req_valid;
    logic              io_pcr_req_ready = 1'b0;
    logic              io_pcr_req_bits_rw;
    logic [ADDR_W-1:0] io_pcr_req_bits_addr;
    logic [DATA_W-1:0] io_pcr_req_bits_data;
    logic              io_pcr_rep_valid = 1'b0;
    logic [DATA_W-1:0] io_pcr_rep_bits = '0;
    logic              io_resp_valid;
    logic              io_resp_ready = 1'b0;
    logic [DATA_W-1:0] io_resp_bits_data;
    logic              io_resp_bits_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   req_hs   = 0;
    exp_t sb_q[$];

    pcr_req_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .io_cmd_valid         (io_cmd_valid),
        .io_cmd_ready         (io_cmd_ready),
        .io_cmd_bits_rw       (io_cmd_bits_rw),
        .io_cmd_bits_addr     (io_cmd_bits_addr),
        .io_cmd_bits_data     (io_cmd_bits_data),
        .io_pcr_req_valid     (io_pcr_req_valid),
        .io_pcr_req_ready     (io_pcr_req_ready),
        .io_pcr_req_bits_rw   (io_pcr_req_bits_rw),
        .io_pcr_req_bits_addr (io_pcr_req_bits_addr),
        .io_pcr_req_bits_data (io_pcr_req_bits_data),
        .io_pcr_rep_valid     (io_pcr_rep_valid),
        .io_pcr_rep_bits      (io_pcr_rep_bits),
        .io_resp_valid        (io_resp_valid),
        .io_resp_ready        (io_resp_ready),
        .io_resp_bits_data    (io_resp_bits_data),
        .io_resp_bits_err     (io_resp_bits_err)
    );

    always #5 clk = ~clk;

    // Count request handshakes seen on the PCR side.
    always @(posedge clk) begin
        if (!reset && io_pcr_req_valid && io_pcr_req_ready) req_hs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer a command in IDLE; returns one cycle later with the DUT in REQ.
    task automatic send_cmd(input string tag, input logic rw, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, input exp_t exp);
        check({tag, "_cmd_ready"}, 64'(io_cmd_ready), 64'd1);
        io_cmd_valid     = 1'b1;
        io_cmd_bits_rw   = rw;
        io_cmd_bits_addr = addr;
        io_cmd_bits_data = data;
        step();
        io_cmd_valid = 1'b0;
        sb_q.push_back(exp);
        check({tag, "_req_valid"}, 64'(io_pcr_req_valid), 64'd1);
        check({tag, "_req_rw"},    64'(io_pcr_req_bits_rw), 64'(rw));
        check({tag, "_req_addr"},  64'(io_pcr_req_bits_addr), 64'(addr));
        check({tag, "_req_data"},  io_pcr_req_bits_data, data);
        check({tag, "_cmd_busy"},  64'(io_cmd_ready), 64'd0);
    endtask

    // Wait (bounded) for a response, compare against the scoreboard, handshake.
    task automatic finish_resp(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (!io_resp_valid && k < 20) begin
            step();
            k++;
        end
        check({tag, "_resp_valid"}, 64'(io_resp_valid), 64'd1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_sb observed=response expected=none queued", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_resp_data"}, io_resp_bits_data, e.data);
            check({tag, "_resp_err"},  64'(io_resp_bits_err), 64'(e.err));
        end
        io_resp_ready = 1'b1;
        step();
        io_resp_ready = 1'b0;
        check({tag, "_idle_resp_valid"}, 64'(io_resp_valid), 64'd0);
        check({tag, "_idle_cmd_ready"},  64'(io_cmd_ready), 64'd1);
    endtask

    initial begin
        exp_t e;
        int   hs0;
        int   k;

        // Reset state
        reset = 1'b1;
        step();
        step();
        check("rst_cmd_ready",  64'(io_cmd_ready), 64'd1);
        check("rst_req_valid",  64'(io_pcr_req_valid), 64'd0);
        check("rst_resp_valid", 64'(io_resp_valid), 64'd0);
        check("rst_resp_data",  io_resp_bits_data, 64'd0);
        check("rst_resp_err",   64'(io_resp_bits_err), 64'd0);
        check("rst_req_rw",     64'(io_pcr_req_bits_rw), 64'd0);
        check("rst_req_addr",   64'(io_pcr_req_bits_addr), 64'd0);
        check("rst_req_data",   io_pcr_req_bits_data, 64'd0);
        reset = 1'b0;
        step();

        // Read addr 5, immediate req_ready, reply on WAIT cycle 2
        io_pcr_req_ready = 1'b1;
        e = '{data: 64'h0000_0000_0000_00A5, err: 1'b0};
        send_cmd("rd5", 1'b0, 5'd5, 64'h1111_2222_3333_4444, e);
        step();
        check("rd5_wait1_req_valid", 64'(io_pcr_req_valid), 64'd0);
        check("rd5_wait1_resp_valid", 64'(io_resp_valid), 64'd0);
        step();
        io_pcr_rep_valid = 1'b1;
        io_pcr_rep_bits  = 64'h0000_0000_0000_00A5;
        step();
        io_pcr_rep_valid = 1'b0;
        finish_resp("rd5");

        // Write addr 3 with req_ready low 4 cycles and a stray reply in REQ
        io_pcr_req_ready = 1'b0;
        e = '{data: 64'h1234, err: 1'b0};
        send_cmd("wr3", 1'b1, 5'd3, 64'hFF, e);
        hs0 = req_hs;
        for (int i = 0; i < 4; i++) begin
            check("wr3_hold_valid", 64'(io_pcr_req_valid), 64'd1);
            check("wr3_hold_rw",    64'(io_pcr_req_bits_rw), 64'd1);
            check("wr3_hold_addr",  64'(io_pcr_req_bits_addr), 64'd3);
            check("wr3_hold_data",  io_pcr_req_bits_data, 64'hFF);
            io_pcr_rep_valid = (i == 1);
            io_pcr_rep_bits  = 64'hDEAD;
            step();
        end
        io_pcr_rep_valid = 1'b0;
        check("wr3_still_req", 64'(io_pcr_req_valid), 64'd1);
        io_pcr_req_ready = 1'b1;
        step();
        io_pcr_req_ready = 1'b0;
        check("wr3_req_dropped", 64'(io_pcr_req_valid), 64'd0);
        check("wr3_one_handshake", 64'(req_hs - hs0), 64'd1);
        step();
        check("wr3_no_resp_before_reply", 64'(io_resp_valid), 64'd0);
        io_pcr_rep_valid = 1'b1;
        io_pcr_rep_bits  = 64'h1234;
        step();
        io_pcr_rep_valid = 1'b0;
        finish_resp("wr3");

        // Timeout: no reply, response exactly TIMEOUT cycles after entering WAIT
        io_pcr_req_ready = 1'b1;
        e = '{data: 64'd0, err: 1'b1};
        send_cmd("to", 1'b0, 5'd7, 64'd0, e);
        step();
        k = 0;
        do begin
            step();
            k++;
        end while (!io_resp_valid && k < 10);
        check("to_latency", 64'(k), 64'(TIMEOUT));
        finish_resp("to");

        // Reply on the 4th WAIT cycle wins over the timeout; stray reply in RESP ignored
        e = '{data: 64'hCAFE_F00D_0000_0001, err: 1'b0};
        send_cmd("race", 1'b0, 5'd12, 64'd0, e);
        step();
        step();
        step();
        step();
        check("race_wait4_no_resp", 64'(io_resp_valid), 64'd0);
        io_pcr_rep_valid = 1'b1;
        io_pcr_rep_bits  = 64'hCAFE_F00D_0000_0001;
        step();
        check("race_resp_valid", 64'(io_resp_valid), 64'd1);
        io_pcr_rep_bits = 64'h0BAD;
        step();
        step();
        io_pcr_rep_valid = 1'b0;
        check("race_stray_data", io_resp_bits_data, 64'hCAFE_F00D_0000_0001);
        check("race_stray_err",  64'(io_resp_bits_err), 64'd0);
        finish_resp("race");

        // Best-case latency, resp_ready low 3 cycles, cmd_valid held high throughout
        check("bp_cmd_ready", 64'(io_cmd_ready), 64'd1);
        io_cmd_valid     = 1'b1;
        io_cmd_bits_rw   = 1'b0;
        io_cmd_bits_addr = 5'd9;
        io_cmd_bits_data = 64'd0;
        step();
        sb_q.push_back('{data: 64'h77, err: 1'b0});
        io_cmd_bits_addr = 5'd10;
        check("bp_req_addr", 64'(io_pcr_req_bits_addr), 64'd9);
        step();
        check("bp_wait_cmd_ready", 64'(io_cmd_ready), 64'd0);
        io_pcr_rep_valid = 1'b1;
        io_pcr_rep_bits  = 64'h77;
        step();
        io_pcr_rep_valid = 1'b0;
        check("bp_latency3_resp_valid", 64'(io_resp_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid",     64'(io_resp_valid), 64'd1);
            check("bp_hold_data",      io_resp_bits_data, 64'h77);
            check("bp_hold_err",       64'(io_resp_bits_err), 64'd0);
            check("bp_hold_cmd_ready", 64'(io_cmd_ready), 64'd0);
            step();
        end
        e = sb_q.pop_front();
        check("bp_resp_data", io_resp_bits_data, e.data);
        check("bp_resp_err",  64'(io_resp_bits_err), 64'(e.err));
        io_resp_ready = 1'b1;
        step();
        io_resp_ready = 1'b0;
        check("bp_after_hs_cmd_ready",  64'(io_cmd_ready), 64'd1);
        check("bp_after_hs_resp_valid", 64'(io_resp_valid), 64'd0);
        step();
        io_cmd_valid = 1'b0;
        check("bp_second_cmd_req_valid", 64'(io_pcr_req_valid), 64'd1);
        check("bp_second_cmd_addr",      64'(io_pcr_req_bits_addr), 64'd10);

        // Reset during WAIT abandons the transaction
        step();
        check("rstw_in_wait", 64'(io_pcr_req_valid), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstw_cmd_ready",  64'(io_cmd_ready), 64'd1);
        check("rstw_resp_valid", 64'(io_resp_valid), 64'd0);
        check("rstw_req_valid",  64'(io_pcr_req_valid), 64'd0);
        check("rstw_req_addr",   64'(io_pcr_req_bits_addr), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstw_quiet_resp_valid", 64'(io_resp_valid), 64'd0);
        end

        // Read after the abandoned transaction completes normally
        e = '{data: 64'h42, err: 1'b0};
        send_cmd("post", 1'b0, 5'd2, 64'd0, e);
        step();
        io_pcr_rep_valid = 1'b1;
        io_pcr_rep_bits  = 64'h42;
        step();
        io_pcr_rep_valid = 1'b0;
        finish_resp("post");
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
